fft_frame_buffer: RTL and testbench

Converts a serial sample stream into complete parallel frames of SIZE samples for the combinational FFT stage, which consumes a whole frame at once. Two ping-pong banks let one frame fill while the previous one is held stable on the frame bus until the downstream stage accepts it. Both sides use valid/ready handshakes, so no sample is dropped or duplicated.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_frame_bank.sv | 35 +++
 rtl/fft_frame_buffer.sv | 109 ++++++++++
 tb/tb_fft_frame_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT front end: per-bank fill state and the default sample type.
package fft_pkg;

    localparam int unsigned DEFAULT_BITS = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef logic signed [DEFAULT_BITS-1:0] sample_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame-sized register bank: single indexed write port, whole array visible on the output.
module fft_frame_bank #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned BITS = 32,
    parameter int unsigned IDXW = $clog2(SIZE)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            we_i,
    input  logic [IDXW-1:0]                 idx_i,
    input  logic signed [BITS-1:0]          wdata_i,
    output logic signed [SIZE-1:0][BITS-1:0] data_o
);

    logic signed [SIZE-1:0][BITS-1:0] mem_q;
    logic signed [SIZE-1:0][BITS-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[idx_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Serial-to-parallel frame assembler with ping-pong banks; one bank fills while the other is held
// on the frame bus until the downstream stage accepts it.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [BITS-1:0]           in_data,
    output logic signed [SIZE-1:0][BITS-1:0] frame,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [$clog2(SIZE):0]            fill_count
);

    localparam int unsigned IDXW = $clog2(SIZE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

    bank_state_t     state_q [2];
    bank_state_t     state_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IDXW-1:0] wr_idx_q,  wr_idx_d;

    logic            wr_fire;
    logic            rd_fire;
    logic            bank_we   [2];
    logic signed [SIZE-1:0][BITS-1:0] bank_data [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .SIZE (SIZE),
            .BITS (BITS),
            .IDXW (IDXW)
        ) u_bank (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .we_i    (bank_we[b]),
            .idx_i   (wr_idx_q),
            .wdata_i (in_data),
            .data_o  (bank_data[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    // A write and a read can fire together only on different banks: the write bank is
    // never FULL and the read bank must be FULL, so both updates apply independently.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        if (clear) begin
            state_d[0] = EMPTY;
            state_d[1] = EMPTY;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_idx_d   = '0;
        end else begin
            if (wr_fire) begin
                if (wr_idx_q == LAST_IDX) begin
                    state_d[wr_bank_q] = FULL;
                    wr_idx_d           = '0;
                    wr_bank_d          = ~wr_bank_q;
                end else begin
                    state_d[wr_bank_q] = FILLING;
                    wr_idx_d           = wr_idx_q + IDXW'(1);
                end
            end
            if (rd_fire) begin
                state_d[rd_bank_q] = EMPTY;
                rd_bank_d          = ~rd_bank_q;
            end
        end
    end

    always_comb begin
        in_ready    = (state_q[wr_bank_q] != FULL);
        frame_valid = (state_q[rd_bank_q] == FULL);
        frame       = bank_data[rd_bank_q];
        fill_count  = in_ready ? {1'b0, wr_idx_q} : '0;
        wr_fire     = in_valid && in_ready && !clear;
        rd_fire     = frame_valid && frame_ready && !clear;
        bank_we[0]  = wr_fire && (wr_bank_q == 1'b0);
        bank_we[1]  = wr_fire && (wr_bank_q == 1'b1);
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: fill, backpressure, simultaneous events, clear,
// asynchronous reset and a randomly gapped streaming run against a sample queue.
module tb_fft_frame_buffer;

    localparam int unsigned SIZE = 8;
    localparam int unsigned BITS = 32;
    localparam int unsigned FW   = SIZE * BITS;

    logic                             clk = 1'b0;
    logic                             rst_n;
    logic                             clear;
    logic                             in_valid;
    logic                             in_ready;
    logic signed [BITS-1:0]           in_data;
    logic signed [SIZE-1:0][BITS-1:0] frame;
    logic                             frame_valid;
    logic                             frame_ready;
    logic [$clog2(SIZE):0]            fill_count;

    int checks = 0;
    int errors = 0;

    fft_frame_buffer #(
        .SIZE (SIZE),
        .BITS (BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] expf(input int base);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < SIZE; i++) r[i*BITS +: BITS] = BITS'(base + i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int first, input int last);
        for (int v = first; v <= last; v++) begin
            in_valid = 1'b1;
            in_data  = BITS'(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    logic [BITS-1:0] q[$];
    logic [FW-1:0]   sexp;
    int              sent;
    int              frames;
    logic            prev_fv;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_frame_valid", FW'(frame_valid), FW'(0));
        check("reset_in_ready", FW'(in_ready), FW'(1));
        check("reset_fill_count", FW'(fill_count), FW'(0));
        check("reset_frame", frame, '0);
        rst_n = 1'b1;
        tick();

        // Fill bank 0 with 1..8
        for (int v = 1; v <= 8; v++) begin
            in_valid = 1'b1;
            in_data  = BITS'(v);
            tick();
            if (v == 3) check("fill_count_3", FW'(fill_count), FW'(3));
            if (v == 7) check("fill_fv_early", FW'(frame_valid), FW'(0));
        end
        check("fill_frame_valid", FW'(frame_valid), FW'(1));
        check("fill_frame", frame, expf(1));
        check("fill_in_ready", FW'(in_ready), FW'(1));

        // Both banks full: backpressure
        push_range(9, 16);
        check("bp_in_ready", FW'(in_ready), FW'(0));
        check("bp_frame", frame, expf(1));
        in_valid = 1'b1; in_data = 99;
        tick();
        in_valid = 1'b0;
        check("bp_hold_frame", frame, expf(1));
        check("bp_fill_count", FW'(fill_count), FW'(0));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("pulse_frame", frame, expf(9));
        check("pulse_frame_valid", FW'(frame_valid), FW'(1));
        check("pulse_in_ready", FW'(in_ready), FW'(1));

        // Bank 0 <- 17..24, then release bank 1 so bank 0 is presented
        push_range(17, 24);
        check("refill_in_ready", FW'(in_ready), FW'(0));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("refill_frame", frame, expf(17));

        // Last write to bank 1 coincides with acceptance of bank 0
        push_range(25, 31);
        in_valid = 1'b1; in_data = 32; frame_ready = 1'b1;
        tick();
        in_valid = 1'b0; frame_ready = 1'b0;
        check("simul_frame", frame, expf(25));
        check("simul_frame_valid", FW'(frame_valid), FW'(1));
        check("simul_in_ready", FW'(in_ready), FW'(1));
        check("simul_fill_count", FW'(fill_count), FW'(0));

        // clear with 5 samples partial and one bank FULL, handshakes in same cycle ignored
        push_range(40, 44);
        check("preclear_fill_count", FW'(fill_count), FW'(5));
        clear = 1'b1; in_valid = 1'b1; in_data = 77; frame_ready = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; frame_ready = 1'b0;
        check("clear_frame_valid", FW'(frame_valid), FW'(0));
        check("clear_fill_count", FW'(fill_count), FW'(0));
        check("clear_in_ready", FW'(in_ready), FW'(1));
        push_range(50, 57);
        check("postclear_frame_valid", FW'(frame_valid), FW'(1));
        check("postclear_frame", frame, expf(50));

        // Asynchronous reset between edges with one full and one partial bank
        push_range(60, 62);
        check("prereset_fill_count", FW'(fill_count), FW'(3));
        #2 rst_n = 1'b0;
        #1;
        check("areset_frame_valid", FW'(frame_valid), FW'(0));
        check("areset_in_ready", FW'(in_ready), FW'(1));
        check("areset_fill_count", FW'(fill_count), FW'(0));
        check("areset_frame", frame, '0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        push_range(80, 87);
        check("postreset_frame_valid", FW'(frame_valid), FW'(1));
        check("postreset_frame", frame, expf(80));
        frame_ready = 1'b1;
        tick();
        check("postreset_accept_fv", FW'(frame_valid), FW'(0));

        // Streaming: random gaps, downstream always ready
        sent = 0; frames = 0; prev_fv = 1'b0;
        for (int cyc = 0; cyc < 8000 && (sent < 1000 || frames < 125); cyc++) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            #2;
            if (frame_valid) begin
                check("stream_fv_pulse", FW'(prev_fv), FW'(0));
                check("stream_frame_avail", FW'(q.size() >= SIZE), FW'(1));
                if (q.size() >= SIZE) begin
                    for (int i = 0; i < SIZE; i++) sexp[i*BITS +: BITS] = q.pop_front();
                    check("stream_frame", frame, sexp);
                end
                frames++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            prev_fv = frame_valid;
            tick();
        end
        in_valid = 1'b0;
        check("stream_sent", FW'(sent), FW'(1000));
        check("stream_frames", FW'(frames), FW'(125));
        check("stream_leftover", FW'(q.size()), FW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
